// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_scan_ctrl
// Description : Word-level controller around a bit-serial "1000" Moore
//               sequence detector. Accepts W-bit words over valid/ready,
//               shifts each word MSB-first through the detector, counts
//               pattern completions and returns the count over valid/ready.
// Ports       : clk, clr (sync, active-low)
//               in_data/in_valid/in_ready    - parallel word input
//               ser_bit/ser_en               - serial trace of the scan
//               det_out                      - detector in match state
//               hit_cnt/out_valid/out_ready  - per-word result
//               hit_pos/pos_valid            - first-match index (optional)
//               busy                         - scanning or result pending
// Options     : define SEQ_SCAN_HIT_POS_EN to add hit_pos/pos_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [W-1:0]       in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               ser_bit,
  output logic               ser_en,
  output logic               det_out,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef SEQ_SCAN_HIT_POS_EN
  output logic [$clog2(W)-1:0] hit_pos,
  output logic               pos_valid,
`endif
  output logic               busy
);

  localparam int              IW       = $clog2(W);
  localparam logic [IW-1:0]   LAST_IDX = IW'(W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_e;

  typedef enum logic [2:0] {
    D_S0 = 3'd0,
    D_S1 = 3'd1,
    D_S2 = 3'd2,
    D_S3 = 3'd3,
    D_S4 = 3'd4
  } det_e;

  ctrl_e            state_q, state_d;
  det_e             det_q, det_d;
  det_e             det_nxt;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;
`ifdef SEQ_SCAN_HIT_POS_EN
  logic [IW-1:0]    pos_q, pos_d;
`endif

  always_comb begin
    // Outputs decoded from registered state only
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    ser_en    = (state_q == ST_SHIFT);
    // The word is shifted left, so the MSB side always holds the current bit
    ser_bit   = (state_q == ST_SHIFT) && shreg_q[W-1];
    det_out   = (det_q == D_S4);
    hit_cnt   = cnt_q;

    // Detector transition for the bit presented this cycle
    det_nxt = D_S0;
    case (det_q)
      D_S0:    det_nxt = ser_bit ? D_S1 : D_S0;
      D_S1:    det_nxt = ser_bit ? D_S1 : D_S2;
      D_S2:    det_nxt = ser_bit ? D_S1 : D_S3;
      D_S3:    det_nxt = ser_bit ? D_S1 : D_S4;
      D_S4:    det_nxt = ser_bit ? D_S1 : D_S0;
      default: det_nxt = D_S0;
    endcase
    // S4 is never re-entered from itself, so entering it marks one completion
    hit = (state_q == ST_SHIFT) && (det_nxt == D_S4);

    state_d = state_q;
    det_d   = det_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef SEQ_SCAN_HIT_POS_EN
    pos_d   = pos_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          idx_d   = '0;
          det_d   = D_S0;
          cnt_d   = '0;
`ifdef SEQ_SCAN_HIT_POS_EN
          pos_d   = '0;
`endif
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        det_d   = det_nxt;
        idx_d   = idx_q + 1'b1;
        if (hit) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
`ifdef SEQ_SCAN_HIT_POS_EN
          // Only the first completion in the word records its position
          if (cnt_q == '0) begin
            pos_d = idx_q;
          end
`endif
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Detector holds its final state until the next accept
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      det_q   <= D_S0;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef SEQ_SCAN_HIT_POS_EN
      pos_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_SCAN_HIT_POS_EN
      pos_q   <= pos_d;
`endif
    end
  end

`ifdef SEQ_SCAN_HIT_POS_EN
  assign hit_pos   = pos_q;
  assign pos_valid = (cnt_q != '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_scan_ctrl
// Description : Self-checking bench for seq_scan_ctrl (W=8, CNT_W=4).
//               Directed words with hand-computed results; expected results
//               are queued at issue time and popped by a monitor on every
//               output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_bit;
  logic       ser_en;
  logic       det_out;
  logic [3:0] hit_cnt;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef SEQ_SCAN_HIT_POS_EN
  logic [2:0] hit_pos;
  logic       pos_valid;
`endif

  typedef struct {
    logic [3:0] cnt;
    logic [2:0] pos;
  } exp_t;

  exp_t sb[$];
  exp_t mexp;
  int   checks   = 0;
  int   failures = 0;

  seq_scan_ctrl #(.W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_bit   (ser_bit),
    .ser_en    (ser_en),
    .det_out   (det_out),
    .hit_cnt   (hit_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SEQ_SCAN_HIT_POS_EN
    .hit_pos   (hit_pos),
    .pos_valid (pos_valid),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on every accepted result
  always @(negedge clk) begin
    if (clr && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", hit_cnt);
      end else begin
        mexp = sb.pop_front();
        chk("hit_cnt", {28'd0, hit_cnt}, {28'd0, mexp.cnt});
`ifdef SEQ_SCAN_HIT_POS_EN
        chk("hit_pos", {29'd0, hit_pos}, {29'd0, mexp.pos});
        chk("pos_valid", {31'd0, pos_valid}, {31'd0, (mexp.cnt != 4'd0)});
`endif
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [3:0] ec, input logic [2:0] ep,
                      input logic edet, input int hold);
    int   n;
    int   lat;
    logic ser_ok;
    logic hold_ok;
    exp_t e;
    @(posedge clk); #1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    e.cnt = ec;
    e.pos = ep;
    sb.push_back(e);
    if (hold > 0) out_ready = 1'b0;
    @(posedge clk); #1;                // accept edge
    in_valid = 1'b0;
    in_data  = ~d;                     // must be ignored while scanning
    lat    = 0;
    ser_ok = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (lat > 8 || !ser_en || !busy || in_ready || ser_bit !== d[8-lat]) ser_ok = 1'b0;
    end
    chk("latency", lat, 32'd9);
    chk("serial_stream", {31'd0, ser_ok}, 32'd1);
    chk("det_out_done", {31'd0, det_out}, {31'd0, edet});
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
        if (k > 0) @(negedge clk);
        if (!(out_valid && hit_cnt == ec && !in_ready && busy)) hold_ok = 1'b0;
      end
      chk("hold_stable", {31'd0, hold_ok}, 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;                // output handshake edge
    chk("idle_after_out", {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    logic quiet;
    clr       = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {26'd0, in_ready, out_valid, ser_en, ser_bit, det_out, busy}, 32'b100000);
    chk("reset_hit_cnt", {28'd0, hit_cnt}, 32'd0);
    clr = 1'b1;

    //   data          cnt   pos   det  hold
    send(8'b1000_1000, 4'd2, 3'd3, 1'b1, 0);
    send(8'b0100_0010, 4'd1, 3'd4, 1'b0, 0);
    send(8'hFF,        4'd0, 3'd0, 1'b0, 0);
    send(8'h00,        4'd0, 3'd0, 1'b0, 0);
    send(8'b0000_0001, 4'd0, 3'd0, 1'b0, 0);
    send(8'b0000_0000, 4'd0, 3'd0, 1'b0, 0);   // detector must restart at S0
    send(8'b1000_0000, 4'd1, 3'd3, 1'b0, 5);   // consumer stalls 5 cycles

    // Reset mid-scan: no result for this word
    @(posedge clk); #1;
    in_data  = 8'b1000_1000;
    in_valid = 1'b1;
    @(posedge clk); #1;                // accept
    in_valid = 1'b0;
    @(posedge clk);                    // end of 1st SHIFT cycle
    @(posedge clk); #1;                // end of 2nd SHIFT cycle
    clr = 1'b0;
    @(posedge clk); #1;                // reset applied at end of 3rd
    clr = 1'b1;
    @(negedge clk);
    chk("midscan_reset_outputs", {26'd0, in_ready, out_valid, ser_en, ser_bit, det_out, busy}, 32'b100000);
    chk("midscan_reset_hit_cnt", {28'd0, hit_cnt}, 32'd0);
`ifdef SEQ_SCAN_HIT_POS_EN
    chk("midscan_reset_pos", {28'd0, pos_valid, hit_pos}, 32'd0);
`endif
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || !in_ready) quiet = 1'b0;
    end
    chk("no_result_after_reset", {31'd0, quiet}, 32'd1);

    send(8'b0001_0000, 4'd1, 3'd6, 1'b0, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Word-level controller for the bit-serial "1000" Moore sequence detector.
- Accepts W-bit parallel words over a valid/ready handshake and serialises each word MSB-first into an embedded detector FSM.
- Counts pattern completions per word and returns the count over a second valid/ready handshake.
- Sits between a parallel producer (register/bus side) and the serial detection datapath; sequences load, shift and report.

Parameters:
- W, 8, word width in bits (W >= 4)
- CNT_W, 4, hit-count width; count saturates at 2^CNT_W-1

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, synchronous, active-low (0 = reset on next rising clk edge)
- in_data  in  W  parallel word to scan
- in_valid  in  1  producer has a word
- in_ready  out  1  controller can accept a word
- ser_bit  out  1  bit currently fed to detector (debug/trace)
- ser_en  out  1  ser_bit is valid this cycle
- det_out  out  1  Moore detector output (1 while detector in match state)
- hit_cnt  out  CNT_W  completions in last scanned word
- out_valid  out  1  hit_cnt (and hit_pos) valid
- out_ready  in  1  consumer accepts result
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (clr=0 at rising edge):
  - ctrl FSM=IDLE; detector=S0; shift reg, bit index, hit_cnt all 0.
  - in_ready=1, out_valid=0, ser_en=0, ser_bit=0, det_out=0, busy=0.
  - Applies in any state, including mid-SHIFT; an in-flight word is discarded with no result.
- Ctrl FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. in_valid&in_ready at edge t: latch in_data, clear hit_cnt, detector->S0, index->0, go SHIFT.
  - SHIFT: cycles t+1..t+W, one bit per cycle, MSB (index 0) first. ser_en=1, ser_bit=current bit. Detector advances on each edge. After bit W-1 is consumed, go DONE.
  - DONE: out_valid=1 from cycle t+W+1. Held with stable hit_cnt until out_valid&out_ready, then IDLE.
  - in_ready=0 in SHIFT and DONE. No input accepted while a result is pending.
  - Latency accept->out_valid = W+1 cycles. Max throughput 1 word per W+2 cycles when out_ready=1.
- Detector FSM (Moore, states S0..S4):
  - S0: 1->S1, 0->S0
  - S1: 0->S2, 1->S1
  - S2: 0->S3, 1->S1
  - S3: 0->S4, 1->S1
  - S4: 1->S1, 0->S0
  - det_out = (state==S4), registered-state decode.
- Hit counting: hit_cnt increments on every edge in SHIFT where the detector enters S4, i.e. on the bit completing "1000". Saturating add, no wrap.
- Detector is reset to S0 at each word start. Patterns never span word boundaries.
- After the last bit the detector holds its state through DONE; det_out may stay 1 in DONE. It returns to S0 at the next accept.
- in_data changes while not accepted: ignored.
- out_ready high with out_valid=0: ignored.
- Simultaneous out handshake in DONE and new in_valid: the word is accepted on the following IDLE cycle, not the same edge.

Optional Feature:
- Macro: SEQ_SCAN_HIT_POS_EN
- Defined: adds output ports hit_pos (width clog2(W)) and pos_valid (1).
  - hit_pos = index of the bit that completed the first match in the word.
  - pos_valid=1 iff hit_cnt>0.
  - Both qualified by out_valid and cleared at reset and at accept.
- Not defined: ports and the position register are absent. All other behaviour identical.

Test Plan:
- W=8, in_data=8'b1000_1000, out_ready=1 -> out_valid at accept+9 cycles, hit_cnt=2; with macro, hit_pos=3, pos_valid=1.
- in_data=8'b0100_0010 -> hit_cnt=1; hit_pos=4.
- in_data=8'hFF, then 8'h00 -> hit_cnt=0 each; pos_valid=0.
- 8'b0000_0001 followed by 8'b0000_0000 -> second word hit_cnt=0, proving per-word detector reset.
- 8'b1000_0000 with out_ready=0 for 5 cycles after out_valid -> out_valid and hit_cnt=1 held stable, in_ready=0; result consumed on out_ready=1, in_ready=1 on the next cycle.
- clr=0 at the edge after the 3rd SHIFT cycle of 8'b1000_1000 -> next cycle in IDLE, all outputs at reset values, no out_valid for that word; next accepted word scans correctly.
